// File: rtl/memory_bank_if.sv
// Access bus for memory_bank: one command/address/data request side and a
// registered read-response side.
interface memory_bank_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
);
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

  logic                  chip_select;
  logic                  rE;
  logic                  wE;
  logic                  clear;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  valid;
  logic                  busy;

  modport master (
    output chip_select,
    output rE,
    output wE,
    output clear,
    output address,
    output data,
    input  dataOut,
    input  valid,
    input  busy
  );

  modport slave (
    input  chip_select,
    input  rE,
    input  wE,
    input  clear,
    input  address,
    input  data,
    output dataOut,
    output valid,
    output busy
  );
endinterface

// File: rtl/memory_bank.sv
// Single-port register-file memory with registered read data, selectable
// read-first/write-first collision behaviour and a hardware zeroing sweep.
module memory_bank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned READ_MODE  = 0
) (
  input logic         clock,
  input logic         reset,
  memory_bank_if.slave bus
);
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pointer_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  valid_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  accept;
  logic                  do_clear;
  logic                  do_write;
  logic                  do_read;
  logic [DATA_WIDTH-1:0] rd_word;

  // Clear wins over read/write issued in the same cycle.
  always_comb begin
    accept   = (state_q == StIdle) && bus.chip_select;
    do_clear = accept && bus.clear;
    do_write = accept && bus.wE && !bus.clear;
    do_read  = accept && bus.rE && !bus.clear;
  end

  // Read and write share one address, so any simultaneous access collides.
  always_comb begin
    rd_word = mem_q[bus.address];
    if ((READ_MODE == 1) && do_write) begin
      rd_word = bus.data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == StClear) begin
      mem_q[pointer_q] <= '0;
    end else if (do_write) begin
      mem_q[bus.address] <= bus.data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      pointer_q <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (do_clear) begin
            state_q   <= StClear;
            busy_q    <= 1'b1;
            pointer_q <= '0;
          end else if (do_read) begin
            dout_q  <= rd_word;
            valid_q <= 1'b1;
          end
        end
        StClear: begin
          pointer_q <= pointer_q + ADDR_WIDTH'(1);
          if (pointer_q == LastAddr) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dataOut = dout_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_memory_bank.sv
// Directed bench for memory_bank: a read-first and a write-first 8x8 bank
// driven in lockstep, plus a 32x16 bank for the parameterised case.
module tb_memory_bank;
  logic clock;
  logic reset;
  int   errors;
  int   checks;

  memory_bank_if #(.DATA_WIDTH(8),  .DEPTH(8))  if0 ();
  memory_bank_if #(.DATA_WIDTH(8),  .DEPTH(8))  if1 ();
  memory_bank_if #(.DATA_WIDTH(16), .DEPTH(32)) if2 ();

  memory_bank #(.DATA_WIDTH(8), .DEPTH(8), .READ_MODE(0)) dut0 (
    .clock(clock), .reset(reset), .bus(if0)
  );
  memory_bank #(.DATA_WIDTH(8), .DEPTH(8), .READ_MODE(1)) dut1 (
    .clock(clock), .reset(reset), .bus(if1)
  );
  memory_bank #(.DATA_WIDTH(16), .DEPTH(32), .READ_MODE(0)) dut2 (
    .clock(clock), .reset(reset), .bus(if2)
  );

  assign if1.chip_select = if0.chip_select;
  assign if1.rE          = if0.rE;
  assign if1.wE          = if0.wE;
  assign if1.clear       = if0.clear;
  assign if1.address     = if0.address;
  assign if1.data        = if0.data;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    if0.chip_select = 1'b0; if0.rE = 1'b0; if0.wE = 1'b0; if0.clear = 1'b0;
    if0.address = '0; if0.data = '0;
    if2.chip_select = 1'b0; if2.rE = 1'b0; if2.wE = 1'b0; if2.clear = 1'b0;
    if2.address = '0; if2.data = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    if0.chip_select = 1'b1; if0.wE = 1'b1; if0.address = a; if0.data = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d0, output logic [7:0] d1,
                    output logic v0);
    if0.chip_select = 1'b1; if0.rE = 1'b1; if0.address = a;
    tick();
    idle();
    d0 = if0.dataOut; d1 = if1.dataOut; v0 = if0.valid;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    #12;
    checks++;
    if (if0.dataOut !== 8'h00 || if0.valid !== 1'b0 || if0.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got dataOut=%h valid=%b busy=%b, want 00 0 0",
               if0.dataOut, if0.valid, if0.busy);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_defaults();
    logic [7:0] d0, d1;
    logic       v0;
    wr(3'd3, 8'hA5);
    rd(3'd3, d0, d1, v0);
    checks++;
    if (d0 !== 8'hA5 || v0 !== 1'b1) begin
      errors++;
      $display("FAIL read_a5: got dataOut=%h valid=%b, want a5 1", d0, v0);
    end
    tick();
    checks++;
    if (if0.valid !== 1'b0 || if0.dataOut !== 8'hA5) begin
      errors++;
      $display("FAIL valid_pulse_hold: got valid=%b dataOut=%h, want 0 a5",
               if0.valid, if0.dataOut);
    end
    rd(3'd4, d0, d1, v0);
    checks++;
    if (d0 !== 8'h00 || v0 !== 1'b1) begin
      errors++;
      $display("FAIL read_addr4: got dataOut=%h valid=%b, want 00 1", d0, v0);
    end
  endtask

  task automatic test_chip_select();
    logic [7:0] d0, d1;
    logic       v0;
    if0.chip_select = 1'b0; if0.wE = 1'b1; if0.rE = 1'b1; if0.address = 3'd2;
    if0.data = 8'h3C;
    tick();
    idle();
    checks++;
    if (if0.valid !== 1'b0) begin
      errors++;
      $display("FAIL cs_low_valid: got valid=%b, want 0", if0.valid);
    end
    rd(3'd2, d0, d1, v0);
    checks++;
    if (d0 !== 8'h00) begin
      errors++;
      $display("FAIL cs_low_write: got dataOut=%h, want 00", d0);
    end
  endtask

  task automatic test_collision();
    logic [7:0] d0, d1;
    logic       v0;
    wr(3'd5, 8'h11);
    if0.chip_select = 1'b1; if0.rE = 1'b1; if0.wE = 1'b1; if0.address = 3'd5;
    if0.data = 8'h22;
    tick();
    idle();
    checks++;
    if (if0.dataOut !== 8'h11 || if0.valid !== 1'b1) begin
      errors++;
      $display("FAIL collision_read_first: got %h valid=%b, want 11 1", if0.dataOut, if0.valid);
    end
    checks++;
    if (if1.dataOut !== 8'h22 || if1.valid !== 1'b1) begin
      errors++;
      $display("FAIL collision_write_first: got %h valid=%b, want 22 1", if1.dataOut, if1.valid);
    end
    rd(3'd5, d0, d1, v0);
    checks++;
    if (d0 !== 8'h22 || d1 !== 8'h22) begin
      errors++;
      $display("FAIL collision_stored: got %h/%h, want 22/22", d0, d1);
    end
  endtask

  task automatic test_clear();
    logic [7:0] d0, d1;
    logic       v0;
    int         n;
    bit         bad;
    for (int i = 0; i < 8; i++) wr(3'(i), 8'hFF);
    rd(3'd6, d0, d1, v0);
    // Read and write alongside clear must be dropped.
    if0.chip_select = 1'b1; if0.clear = 1'b1; if0.rE = 1'b1; if0.wE = 1'b1;
    if0.address = 3'd0; if0.data = 8'h55;
    tick();
    idle();
    n = 0;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (if0.busy === 1'b1) n++;
      if (if0.valid !== 1'b0 || if0.dataOut !== 8'hFF) bad = 1'b1;
      if (i == 2) begin
        if0.chip_select = 1'b1; if0.wE = 1'b1; if0.rE = 1'b1; if0.clear = 1'b1;
        if0.address = 3'd1; if0.data = 8'h77;
      end else begin
        idle();
      end
      tick();
    end
    idle();
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL clear_busy_cycles: got %0d, want 8", n);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL clear_ignored_access: valid or dataOut changed during sweep, want 0/ff");
    end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), d0, d1, v0);
      if (d0 !== 8'h00 || d1 !== 8'h00) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL clear_all_zero: got %0d nonzero words, want 0", n);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [7:0] d0, d1;
    logic       v0;
    int         n;
    for (int i = 0; i < 8; i++) wr(3'(i), 8'hFF);
    rd(3'd7, d0, d1, v0);
    if0.chip_select = 1'b1; if0.clear = 1'b1;
    tick();
    idle();
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (if0.busy !== 1'b0 || if0.valid !== 1'b0 || if0.dataOut !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_sweep: got busy=%b valid=%b dataOut=%h, want 0 0 00",
               if0.busy, if0.valid, if0.dataOut);
    end
    @(negedge clock);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), d0, d1, v0);
      if (d0 !== 8'h00 || d1 !== 8'h00) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL reset_mid_sweep_zero: got %0d nonzero words, want 0", n);
    end
  endtask

  task automatic test_param();
    int n;
    if2.chip_select = 1'b1; if2.wE = 1'b1; if2.address = 5'd31; if2.data = 16'hBEEF;
    tick();
    if2.address = 5'd0; if2.data = 16'h1234;
    tick();
    if2.wE = 1'b0; if2.rE = 1'b1; if2.address = 5'd31;
    tick();
    idle();
    checks++;
    if (if2.dataOut !== 16'hBEEF || if2.valid !== 1'b1) begin
      errors++;
      $display("FAIL param_read31: got %h valid=%b, want beef 1", if2.dataOut, if2.valid);
    end
    if2.chip_select = 1'b1; if2.clear = 1'b1;
    tick();
    idle();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (if2.busy === 1'b1) n++;
      tick();
    end
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL param_sweep_cycles: got %0d, want 32", n);
    end
    if2.chip_select = 1'b1; if2.rE = 1'b1; if2.address = 5'd0;
    tick();
    idle();
    checks++;
    if (if2.dataOut !== 16'h0000) begin
      errors++;
      $display("FAIL param_cleared: got %h, want 0000", if2.dataOut);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_defaults();
    test_chip_select();
    test_collision();
    test_clear();
    test_reset_mid_sweep();
    test_param();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
